// File: rtl/mnist_lut_eval_ctl.sv
// Sequences an MNIST LUT-net evaluation run: streams sample addresses, scores each net result
// with a 3-way vote/argmax and tracks match/total counts. Define MNIST_LUT_EVAL_TIMEOUT_EN for the drain watchdog.
module mnist_lut_eval_ctl #(
    parameter int USER_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 14,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cke,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  net_in_valid,
    input  logic [USER_WIDTH-1:0] net_out_user,
    input  logic [29:0]           net_out_data,
    input  logic                  net_out_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [ADDR_WIDTH:0]   match_count,
    output logic [ADDR_WIDTH:0]   total_count,
    output logic [3:0]            result_class,
    output logic                  result_match,
    output logic                  result_valid
);

    localparam int NUM_CLS = 10;
    localparam int STAGES  = 2;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                          state;
    logic [ADDR_WIDTH-1:0]           num_q;
    logic [ADDR_WIDTH:0]             recv_cnt;
    logic [STAGES:1]                 vld_pipe;
    logic [NUM_CLS-1:0][1:0]         votes_d, votes_q;
    logic [USER_WIDTH-1:0]           user_q;
    logic [3:0]                      best_cls;
    logic [1:0]                      best_v;
    logic                            best_match;
    logic                            accept;

    // Results beyond the latched count, or outside a run, never enter the pipeline.
    assign accept       = cke && net_out_valid && busy && (recv_cnt < {1'b0, num_q});
    assign result_valid = vld_pipe[STAGES];

    for (genvar k = 0; k < NUM_CLS; k++) begin : g_vote
        assign votes_d[k] = 2'(net_out_data[k]) + 2'(net_out_data[k+10]) + 2'(net_out_data[k+20]);
    end

    always_comb begin
        best_cls = 4'd15;
        best_v   = 2'd0;
        for (int k = 0; k < NUM_CLS; k++) begin
            if (votes_q[k] > best_v) begin
                best_v   = votes_q[k];
                best_cls = 4'(k);
            end
        end
        best_match = (best_cls != 4'd15) && (USER_WIDTH'(best_cls) == user_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe     <= '0;
            votes_q      <= '0;
            user_q       <= '0;
            result_class <= 4'd15;
            result_match <= 1'b0;
        end else if (cke) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            if (accept) begin
                votes_q <= votes_d;
                user_q  <= net_out_user;
            end
            if (vld_pipe[1]) begin
                result_class <= best_cls;
                result_match <= best_match;
            end
        end
    end

`ifdef MNIST_LUT_EVAL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            num_q        <= '0;
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            net_in_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            recv_cnt     <= '0;
            match_count  <= '0;
            total_count  <= '0;
`ifdef MNIST_LUT_EVAL_TIMEOUT_EN
            wd_cnt       <= '0;
            timeout_q    <= 1'b0;
`endif
        end else if (cke) begin
            net_in_valid <= mem_rd_en;
            if (accept)
                recv_cnt <= recv_cnt + 1'b1;
            if (result_valid) begin
                total_count <= total_count + 1'b1;
                match_count <= match_count + (ADDR_WIDTH+1)'(result_match);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        num_q       <= num;
                        recv_cnt    <= '0;
                        match_count <= '0;
                        total_count <= '0;
`ifdef MNIST_LUT_EVAL_TIMEOUT_EN
                        wd_cnt      <= '0;
                        timeout_q   <= 1'b0;
`endif
                        if (num == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            busy      <= 1'b1;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_addr == num_q - ADDR_WIDTH'(1)) begin
                        mem_rd_en <= 1'b0;
                        mem_addr  <= '0;
                        state     <= DRAIN;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (total_count == {1'b0, num_q} && vld_pipe == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
`ifdef MNIST_LUT_EVAL_TIMEOUT_EN
                    else if (accept) begin
                        wd_cnt <= '0;
                    end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mnist_lut_eval_ctl.sv
// Bench for mnist_lut_eval_ctl: a latency-5 net model echoes table vectors, a scoreboard checks each result.
module tb_mnist_lut_eval_ctl;
    localparam int UW = 8;
    localparam int AW = 14;
    localparam int TO = 32;

    logic clk, reset_n, cke, start;
    logic [AW-1:0] num, mem_addr;
    logic mem_rd_en, net_in_valid, net_out_valid;
    logic [UW-1:0] net_out_user;
    logic [29:0] net_out_data;
    logic busy, done, timeout, result_match, result_valid;
    logic [AW:0] match_count, total_count;
    logic [3:0] result_class;

    mnist_lut_eval_ctl #(.USER_WIDTH(UW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .cke(cke), .start(start), .num(num),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .net_in_valid(net_in_valid),
        .net_out_user(net_out_user), .net_out_data(net_out_data), .net_out_valid(net_out_valid),
        .busy(busy), .done(done), .timeout(timeout),
        .match_count(match_count), .total_count(total_count),
        .result_class(result_class), .result_match(result_match), .result_valid(result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [29:0]   data;
        logic [UW-1:0] user;
        logic [3:0]    cls;
        logic          match;
    } vec_t;
    typedef struct {
        logic v;
        int   a;
    } np_t;

    vec_t tbl[10];
    np_t  np[5];
    int   sb_q[$];
    int   checks = 0, errors = 0;
    int   exp_addr, addr_d, sent, num_cur, done_cnt, cnt;
    bit   net_en, tog, force_v;

    function automatic logic [29:0] vb(input int k, input int n);
        logic [29:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[k + 10*i] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: drive net model, score outputs before the edge, advance net pipe after it.
    task automatic cyc();
        logic c_cke, c_niv, c_rd;
        logic [AW-1:0] c_addr;
        int idx, e;
        cke = tog ? ~cke : 1'b1;
        idx = np[4].a;
        net_out_valid = (net_en && np[4].v) || force_v;
        net_out_data  = force_v ? tbl[0].data : tbl[idx].data;
        net_out_user  = force_v ? tbl[0].user : tbl[idx].user;
        c_cke = cke; c_niv = net_in_valid; c_rd = mem_rd_en; c_addr = mem_addr;
        if (c_cke) begin
            if (net_en && np[4].v && !force_v && sent < num_cur) begin
                sb_q.push_back(idx);
                sent++;
            end
            if (done) done_cnt++;
            if (result_valid) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got class %0d expected no result", result_class);
                end else begin
                    e = sb_q.pop_front();
                    chk("result_class", result_class, tbl[e].cls);
                    chk("result_match", result_match, tbl[e].match);
                end
            end
            if (c_rd) begin
                chk("mem_addr", c_addr, exp_addr);
                chk("read_in_range", exp_addr < num_cur, 1);
                exp_addr++;
            end
        end
        @(posedge clk); #1;
        if (c_cke) begin
            for (int i = 4; i > 0; i--) np[i] = np[i-1];
            np[0] = '{c_niv, addr_d};
            if (c_rd) addr_d = int'(c_addr);
        end
    endtask

    task automatic begin_run(input int n);
        exp_addr = 0; sent = 0; num_cur = n; done_cnt = 0; addr_d = 0;
        sb_q.delete();
        for (int i = 0; i < 5; i++) np[i] = '{1'b0, 0};
        tog = 1'b0; start = 1'b1; num = AW'(n);
        cyc();
        start = 1'b0;
    endtask

    task automatic run(input int n, input bit t, input int exp_match);
        begin_run(n);
        tog = t;
        if (n == 0) chk("done_after_zero_start", done, 1);
        for (int i = 0; i < 400 && done_cnt == 0; i++) cyc();
        if (done_cnt == 0) begin
            checks++; errors++;
            $display("FAIL run_wait: got no done expected done within 400 cycles");
        end
        repeat (4) cyc();
        tog = 1'b0;
        chk("done_pulses", done_cnt, 1);
        chk("addresses_issued", exp_addr, n);
        chk("scoreboard_empty", sb_q.size(), 0);
        chk("total_count", total_count, n);
        chk("match_count", match_count, exp_match);
        chk("busy_after_run", busy, 0);
    endtask

    initial begin
        tbl[0] = '{vb(3,3),           8'd3,   4'd3,  1'b1};
        tbl[1] = '{vb(7,3),           8'd7,   4'd7,  1'b1};
        tbl[2] = '{vb(0,3),           8'd0,   4'd0,  1'b1};
        tbl[3] = '{vb(2,2) | vb(7,2), 8'd7,   4'd2,  1'b0};
        tbl[4] = '{30'd0,             8'd5,   4'd15, 1'b0};
        tbl[5] = '{vb(9,1) | vb(4,1), 8'd9,   4'd4,  1'b0};
        tbl[6] = '{vb(5,3) | vb(6,2), 8'd5,   4'd5,  1'b1};
        tbl[7] = '{vb(8,1),           8'd8,   4'd8,  1'b1};
        tbl[8] = '{vb(1,2) | vb(9,3), 8'd1,   4'd9,  1'b0};
        tbl[9] = '{vb(6,1),           8'd200, 4'd6,  1'b0};
        for (int i = 0; i < 5; i++) np[i] = '{1'b0, 0};

        reset_n = 1'b0; cke = 1'b1; start = 1'b0; num = '0;
        net_out_valid = 1'b0; net_out_data = '0; net_out_user = '0;
        net_en = 1'b1; tog = 1'b0; force_v = 1'b0; num_cur = 0; addr_d = 0; exp_addr = 0; sent = 0;
        repeat (2) @(posedge clk); #1;
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_net_in_valid", net_in_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_result_class", result_class, 15);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_counts", {match_count, total_count}, 0);
        reset_n = 1'b1;
        repeat (2) cyc();

        run(3, 1'b0, 3);
        force_v = 1'b1;
        repeat (3) cyc();
        force_v = 1'b0;
        repeat (4) cyc();
        chk("idle_results_ignored", total_count, 3);

        run(10, 1'b0, 5);
        run(10, 1'b1, 5);
        run(0, 1'b0, 0);

        // Reset in the middle of the address stream.
        begin_run(10);
        for (int i = 0; i < 20 && mem_addr != AW'(4); i++) cyc();
        chk("reached_addr4", mem_addr, 4);
        reset_n = 1'b0;
        #1;
        chk("midrst_mem_rd_en", mem_rd_en, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_net_in_valid", net_in_valid, 0);
        chk("midrst_result_class", result_class, 15);
        num_cur = 0; sb_q.delete();
        repeat (2) cyc();
        reset_n = 1'b1;
        repeat (12) cyc();
        chk("post_rst_total", total_count, 0);
        chk("post_rst_busy", busy, 0);

        // Silent net: drain either times out or waits.
        net_en = 1'b0;
        begin_run(2);
        for (int i = 0; i < 10 && mem_rd_en; i++) cyc();
        chk("drain_entered", mem_rd_en, 0);
`ifdef MNIST_LUT_EVAL_TIMEOUT_EN
        cnt = 0;
        for (int i = 0; i < TO + 20 && !timeout; i++) begin
            cyc();
            cnt++;
        end
        chk("timeout_cycles", cnt, TO);
        chk("timeout_flag", timeout, 1);
        chk("timeout_done", done, 1);
        repeat (3) cyc();
        chk("timeout_held", timeout, 1);
        chk("timeout_idle_busy", busy, 0);
`else
        repeat (TO + 20) cyc();
        chk("no_watchdog_timeout", timeout, 0);
        chk("no_watchdog_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("exit_rst_busy", busy, 0);
        reset_n = 1'b1;
`endif
        net_en = 1'b1;
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
